// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects and load-extends the MEM/WB result, then commits it into
// a 32x32 register file with two write-through read ports, EX forwarding and commit debug state.
module wb_regfile_stage #(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_mem_read_data_in,
    input  logic [31:0]      wb_alu_result_in,
    input  logic [31:0]      wb_pc_plus4_in,
    input  logic [4:0]       wb_rd_in,
    input  logic [2:0]       wb_load_funct3_in,
    input  logic             wb_regwrite_in,
    input  logic             wb_memtoreg_in,
    input  logic             wb_jal_in,
    input  logic             wb_jalr_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic [31:0]      wb_fwd_data,
    output logic [4:0]       wb_fwd_rd,
    output logic             wb_fwd_en,
    output logic [CNT_W-1:0] commit_count,
    output logic [4:0]       last_wr_rd,
    output logic [31:0]      last_wr_data
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Byte/half extraction by address offset; half-word ignores off[0] (no misalign trap).
    function automatic logic [31:0] load_extend(
        input logic [31:0] raw,
        input logic [1:0]  off,
        input logic [2:0]  funct3
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        if (off[1]) begin
            half_v = raw[31:16];
        end else begin
            half_v = raw[15:0];
        end
        case (funct3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'h00_0000, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b101:  res_v = {16'h0000, half_v};
            default: res_v = raw;
        endcase
        return res_v;
    endfunction

    logic [31:0]      regs_r [32];
    logic [31:0]      wr_data_s;
    logic [31:0]      fwd_data_s;
    logic             fwd_en_s;
    logic [31:0]      rs1_data_s;
    logic [31:0]      rs2_data_s;
    logic [CNT_W-1:0] commit_count_r;
    logic [4:0]       last_wr_rd_r;
    logic [31:0]      last_wr_data_r;

    // Write-back value: link beats load, load beats ALU result.
    always_comb begin
        wr_data_s = 32'h0000_0000;
        if (wb_jal_in || wb_jalr_in) begin
            wr_data_s = wb_pc_plus4_in;
        end else if (wb_memtoreg_in) begin
            wr_data_s = load_extend(wb_mem_read_data_in, wb_alu_result_in[1:0], wb_load_funct3_in);
        end else begin
            wr_data_s = wb_alu_result_in;
        end
    end

    // Forwarding view of the write; everything reads as zero while in reset.
    always_comb begin
        fwd_en_s   = 1'b0;
        fwd_data_s = 32'h0000_0000;
        if (rst) begin
            fwd_en_s   = 1'b0;
            fwd_data_s = 32'h0000_0000;
        end else begin
            fwd_en_s   = wb_regwrite_in && (wb_rd_in != 5'd0);
            fwd_data_s = wr_data_s;
        end
    end

    // Read port 1 with write-through bypass of the commit in flight.
    always_comb begin
        rs1_data_s = 32'h0000_0000;
        if (rst || (rs1_addr == 5'd0)) begin
            rs1_data_s = 32'h0000_0000;
        end else if (fwd_en_s && (rs1_addr == wb_rd_in)) begin
            rs1_data_s = fwd_data_s;
        end else begin
            rs1_data_s = regs_r[rs1_addr];
        end
    end

    // Read port 2 with write-through bypass of the commit in flight.
    always_comb begin
        rs2_data_s = 32'h0000_0000;
        if (rst || (rs2_addr == 5'd0)) begin
            rs2_data_s = 32'h0000_0000;
        end else if (fwd_en_s && (rs2_addr == wb_rd_in)) begin
            rs2_data_s = fwd_data_s;
        end else begin
            rs2_data_s = regs_r[rs2_addr];
        end
    end

    // Register storage, commit counter and last-write debug registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= (i == 2) ? SP_INIT : 32'h0000_0000;
            end
            commit_count_r <= CNT_ZERO;
            last_wr_rd_r   <= 5'd0;
            last_wr_data_r <= 32'h0000_0000;
        end else if (fwd_en_s) begin
            regs_r[wb_rd_in] <= wr_data_s;
            commit_count_r   <= commit_count_r + CNT_ONE;
            last_wr_rd_r     <= wb_rd_in;
            last_wr_data_r   <= wr_data_s;
        end else begin
            commit_count_r <= commit_count_r;
            last_wr_rd_r   <= last_wr_rd_r;
            last_wr_data_r <= last_wr_data_r;
        end
    end

    assign rs1_data     = rs1_data_s;
    assign rs2_data     = rs2_data_s;
    assign wb_fwd_data  = fwd_data_s;
    assign wb_fwd_rd    = wb_rd_in;
    assign wb_fwd_en    = fwd_en_s;
    assign commit_count = commit_count_r;
    assign last_wr_rd   = last_wr_rd_r;
    assign last_wr_data = last_wr_data_r;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage (CNT_W=4 so the counter wrap is reachable).
module tb_wb_regfile_stage;

    localparam int          CNT_W = 4;
    localparam logic [31:0] SP    = 32'h0000_8000;

    logic             clk;
    logic             rst;
    logic [31:0]      wb_mem_read_data_in;
    logic [31:0]      wb_alu_result_in;
    logic [31:0]      wb_pc_plus4_in;
    logic [4:0]       wb_rd_in;
    logic [2:0]       wb_load_funct3_in;
    logic             wb_regwrite_in;
    logic             wb_memtoreg_in;
    logic             wb_jal_in;
    logic             wb_jalr_in;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      wb_fwd_data;
    logic [4:0]       wb_fwd_rd;
    logic             wb_fwd_en;
    logic [CNT_W-1:0] commit_count;
    logic [4:0]       last_wr_rd;
    logic [31:0]      last_wr_data;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_count;

    // Load-extension vectors for raw word 32'h8081_F27F.
    logic [2:0]  f3_tab  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
    logic [1:0]  off_tab [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [31:0] exp_tab [8] = '{32'h0000_007F, 32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081,
                                 32'h0000_F27F, 32'h8081_F27F, 32'hFFFF_8081, 32'h8081_F27F};

    wb_regfile_stage #(.CNT_W(CNT_W), .SP_INIT(SP)) dut (
        .clk(clk), .rst(rst),
        .wb_mem_read_data_in(wb_mem_read_data_in), .wb_alu_result_in(wb_alu_result_in),
        .wb_pc_plus4_in(wb_pc_plus4_in), .wb_rd_in(wb_rd_in),
        .wb_load_funct3_in(wb_load_funct3_in), .wb_regwrite_in(wb_regwrite_in),
        .wb_memtoreg_in(wb_memtoreg_in), .wb_jal_in(wb_jal_in), .wb_jalr_in(wb_jalr_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_fwd_data(wb_fwd_data), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_en(wb_fwd_en),
        .commit_count(commit_count), .last_wr_rd(last_wr_rd), .last_wr_data(last_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_regwrite_in = 1'b0; wb_memtoreg_in = 1'b0; wb_jal_in = 1'b0; wb_jalr_in = 1'b0;
        wb_load_funct3_in = 3'b010; wb_rd_in = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        wb_regwrite_in = 1'b1; wb_rd_in = 5'd5; wb_alu_result_in = 32'h5555_AAAA;
        rs1_addr = 5'd5; rs2_addr = 5'd2;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_rs1 cyc%0d got %h exp 0", c, rs1_data); end
            checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rst_rs2 cyc%0d got %h exp 0", c, rs2_data); end
            checks++; if (wb_fwd_data !== 32'h0) begin errors++; $display("FAIL rst_fwd_data cyc%0d got %h exp 0", c, wb_fwd_data); end
            checks++; if (wb_fwd_en !== 1'b0) begin errors++; $display("FAIL rst_fwd_en cyc%0d got %b exp 0", c, wb_fwd_en); end
            @(posedge clk);
        end
        #1;
        rst = 1'b0; idle();
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rst_x5 got %h exp 0", rs1_data); end
        checks++; if (rs2_data !== SP) begin errors++; $display("FAIL rst_x2 got %h exp %h", rs2_data, SP); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", commit_count); end
        checks++; if (last_wr_rd !== 5'd0) begin errors++; $display("FAIL rst_last_rd got %0d exp 0", last_wr_rd); end
        checks++; if (last_wr_data !== 32'h0) begin errors++; $display("FAIL rst_last_data got %h exp 0", last_wr_data); end
        exp_count = 4'd0;
    endtask

    task automatic test_alu_bypass();
        idle();
        wb_regwrite_in = 1'b1; wb_rd_in = 5'd7; wb_alu_result_in = 32'hDEAD_BEEF;
        rs1_addr = 5'd7; rs2_addr = 5'd2;
        #1;
        checks++; if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs1 got %h exp DEADBEEF", rs1_data); end
        checks++; if (rs2_data !== SP) begin errors++; $display("FAIL bypass_rs2_nohit got %h exp %h", rs2_data, SP); end
        checks++; if (wb_fwd_en !== 1'b1) begin errors++; $display("FAIL bypass_fwd_en got %b exp 1", wb_fwd_en); end
        checks++; if (wb_fwd_rd !== 5'd7) begin errors++; $display("FAIL bypass_fwd_rd got %0d exp 7", wb_fwd_rd); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL bypass_count_pre got %0d exp 0", commit_count); end
        tick();
        idle();
        exp_count = exp_count + 4'd1;
        #1;
        checks++; if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_x7 got %h exp DEADBEEF", rs1_data); end
        checks++; if (commit_count !== exp_count) begin errors++; $display("FAIL alu_count got %0d exp %0d", commit_count, exp_count); end
        checks++; if (last_wr_rd !== 5'd7) begin errors++; $display("FAIL alu_last_rd got %0d exp 7", last_wr_rd); end
        checks++; if (last_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_last_data got %h exp DEADBEEF", last_wr_data); end
    endtask

    task automatic test_load_ext();
        wb_mem_read_data_in = 32'h8081_F27F;
        for (int i = 0; i < 8; i++) begin
            idle();
            wb_regwrite_in = 1'b1; wb_memtoreg_in = 1'b1; wb_rd_in = 5'(10 + i);
            wb_load_funct3_in = f3_tab[i]; wb_alu_result_in = {30'h0000_0400, off_tab[i]};
            #1;
            checks++; if (wb_fwd_data !== exp_tab[i]) begin errors++; $display("FAIL load_fwd[%0d] got %h exp %h", i, wb_fwd_data, exp_tab[i]); end
            tick();
            exp_count = exp_count + 4'd1;
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            rs1_addr = 5'(10 + i); rs2_addr = 5'(17 - i);
            #1;
            checks++; if (rs1_data !== exp_tab[i]) begin errors++; $display("FAIL load_stored[%0d] got %h exp %h", i, rs1_data, exp_tab[i]); end
            checks++; if (rs2_data !== exp_tab[7 - i]) begin errors++; $display("FAIL load_stored_p2[%0d] got %h exp %h", i, rs2_data, exp_tab[7 - i]); end
        end
        checks++; if (commit_count !== exp_count) begin errors++; $display("FAIL load_count got %0d exp %0d", commit_count, exp_count); end
        checks++; if (last_wr_rd !== 5'd17) begin errors++; $display("FAIL load_last_rd got %0d exp 17", last_wr_rd); end
    endtask

    task automatic test_x0_link();
        idle();
        wb_regwrite_in = 1'b1; wb_rd_in = 5'd0; wb_alu_result_in = 32'd1234;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_rs1 got %h exp 0", rs1_data); end
        checks++; if (wb_fwd_en !== 1'b0) begin errors++; $display("FAIL x0_fwd_en got %b exp 0", wb_fwd_en); end
        tick();
        idle();
        #1;
        checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL x0_stored got %h exp 0", rs2_data); end
        checks++; if (commit_count !== exp_count) begin errors++; $display("FAIL x0_count got %0d exp %0d", commit_count, exp_count); end
        wb_regwrite_in = 1'b1; wb_jal_in = 1'b1; wb_memtoreg_in = 1'b1; wb_rd_in = 5'd1;
        wb_pc_plus4_in = 32'h0000_0100; wb_alu_result_in = 32'h0000_0001; wb_load_funct3_in = 3'b000;
        #1;
        checks++; if (wb_fwd_data !== 32'h0000_0100) begin errors++; $display("FAIL jal_fwd got %h exp 00000100", wb_fwd_data); end
        tick();
        exp_count = exp_count + 4'd1;
        idle();
        wb_regwrite_in = 1'b1; wb_jalr_in = 1'b1; wb_rd_in = 5'd3;
        wb_pc_plus4_in = 32'h0000_0204; wb_alu_result_in = 32'h7777_0000;
        tick();
        exp_count = exp_count + 4'd1;
        idle();
        rs1_addr = 5'd1; rs2_addr = 5'd3;
        #1;
        checks++; if (rs1_data !== 32'h0000_0100) begin errors++; $display("FAIL jal_x1 got %h exp 00000100", rs1_data); end
        checks++; if (rs2_data !== 32'h0000_0204) begin errors++; $display("FAIL jalr_x3 got %h exp 00000204", rs2_data); end
        checks++; if (commit_count !== exp_count) begin errors++; $display("FAIL link_count got %0d exp %0d", commit_count, exp_count); end
    endtask

    task automatic test_dual_port_reset();
        idle();
        rst = 1'b1; wb_regwrite_in = 1'b1; wb_rd_in = 5'd9; wb_alu_result_in = 32'hCAFE_F00D;
        tick();
        rst = 1'b0; idle();
        rs1_addr = 5'd9; rs2_addr = 5'd7;
        exp_count = 4'd0;
        #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rstprio_x9 got %h exp 0", rs1_data); end
        checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL rstprio_x7 got %h exp 0", rs2_data); end
        checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL rstprio_count got %0d exp 0", commit_count); end
        wb_regwrite_in = 1'b1; wb_rd_in = 5'd9; wb_alu_result_in = 32'h1357_9BDF;
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        #1;
        checks++; if (rs1_data !== 32'h1357_9BDF) begin errors++; $display("FAIL dual_rs1 got %h exp 13579BDF", rs1_data); end
        checks++; if (rs2_data !== 32'h1357_9BDF) begin errors++; $display("FAIL dual_rs2 got %h exp 13579BDF", rs2_data); end
        tick();
        exp_count = exp_count + 4'd1;
        idle();
        #1;
        checks++; if (rs2_data !== 32'h1357_9BDF) begin errors++; $display("FAIL dual_stored got %h exp 13579BDF", rs2_data); end
        checks++; if (last_wr_data !== 32'h1357_9BDF) begin errors++; $display("FAIL dual_last_data got %h exp 13579BDF", last_wr_data); end
    endtask

    task automatic test_back_to_back_wrap();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 4'd0;
        rs1_addr = 5'd20; rs2_addr = 5'd2;
        for (int i = 1; i <= 17; i++) begin
            wb_regwrite_in = 1'b1; wb_rd_in = 5'd20; wb_alu_result_in = 32'(i * 32'h0101);
            #1;
            checks++; if (rs1_data !== 32'(i * 32'h0101)) begin errors++; $display("FAIL b2b_bypass[%0d] got %h exp %h", i, rs1_data, 32'(i * 32'h0101)); end
            tick();
            exp_count = exp_count + 4'd1;
            if (i == 15) begin
                checks++; if (commit_count !== 4'hF) begin errors++; $display("FAIL wrap_allones got %0d exp 15", commit_count); end
            end else if (i == 16) begin
                checks++; if (commit_count !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", commit_count); end
            end else if (i == 17) begin
                checks++; if (commit_count !== 4'd1) begin errors++; $display("FAIL wrap_one got %0d exp 1", commit_count); end
            end else begin
                checks++; if (commit_count !== exp_count) begin errors++; $display("FAIL wrap_step[%0d] got %0d exp %0d", i, commit_count, exp_count); end
            end
        end
        idle();
        #1;
        checks++; if (rs1_data !== 32'h0000_1111) begin errors++; $display("FAIL b2b_final got %h exp 00001111", rs1_data); end
        checks++; if (rs2_data !== SP) begin errors++; $display("FAIL b2b_sp got %h exp %h", rs2_data, SP); end
        checks++; if (last_wr_rd !== 5'd20) begin errors++; $display("FAIL b2b_last_rd got %0d exp 20", last_wr_rd); end
    endtask

    initial begin
        rst = 1'b1;
        wb_mem_read_data_in = 32'h0; wb_alu_result_in = 32'h0; wb_pc_plus4_in = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        exp_count = 4'd0;
        idle();
        test_reset();
        test_alu_bypass();
        test_load_ext();
        test_x0_link();
        test_dual_port_reset();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
